encode: RTL and testbench

//   Registered rate-1/2 Fink (Hagelbarger-type) recurrent burst-correcting encoder.

---
 rtl/encode.sv | 43 ++++
 tb/tb_encode.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/encode.sv
// Rate-1/2 Fink/Hagelbarger recurrent burst-correcting encoder.
// Message plus 2*D flush zeros, info/check bits interleaved, one-cycle registered.
module encode #(
    parameter int MSG_SIZE = 6,
    parameter int STEP = 0,
    localparam int D = 2 * STEP + 1,
    localparam int L = MSG_SIZE + 2 * D,
    localparam int CODED_MSG_SIZE = 2 * L
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [MSG_SIZE-1:0]       msg_in,
    output logic [CODED_MSG_SIZE-1:0] msg_out
);

    logic [L-1:0]              info;
    logic [L-1:0]              check;
    logic [CODED_MSG_SIZE-1:0] code;

    assign info = {{(2 * D){1'b0}}, msg_in};

    // Taps reaching below index 0 read as zero, so early slots use fewer terms.
    for (genvar k = 0; k < L; k++) begin : g_check
        if (k >= 2 * D) begin : g_two
            assign check[k] = info[k-D] ^ info[k-2*D];
        end else if (k >= D) begin : g_one
            assign check[k] = info[k-D];
        end else begin : g_none
            assign check[k] = 1'b0;
        end
        assign code[2*k]   = info[k];
        assign code[2*k+1] = check[k];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msg_out <= '0;
        end else begin
            msg_out <= code;
        end
    end

endmodule

// File: tb/tb_encode.sv
// Bench for encode: directed and random stimulus against a scoreboard of
// expected codewords, for STEP=0 (16-bit) and STEP=1 (24-bit) instances.
module tb_encode;

    logic        clk;
    logic        rst;
    logic [5:0]  msg_in;
    logic [15:0] out0;
    logic [23:0] out1;

    int compared = 0;
    int mismatched = 0;

    logic [15:0] q0[$];
    logic [23:0] q1[$];

    encode #(.MSG_SIZE(6), .STEP(0)) dut0 (
        .clk(clk), .rst(rst), .msg_in(msg_in), .msg_out(out0)
    );

    encode #(.MSG_SIZE(6), .STEP(1)) dut1 (
        .clk(clk), .rst(rst), .msg_in(msg_in), .msg_out(out1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_code(input int ms, input int step,
                                             input logic [31:0] m);
        int d;
        int l;
        logic [63:0] r;
        logic ak;
        logic pk;
        d = 2 * step + 1;
        l = ms + 2 * d;
        r = '0;
        for (int k = 0; k < l; k++) begin
            ak = (k < ms) ? m[k] : 1'b0;
            pk = 1'b0;
            if (k >= d && k - d < ms) pk = pk ^ m[k-d];
            if (k >= 2 * d && k - 2 * d < ms) pk = pk ^ m[k-2*d];
            r[2*k]   = ak;
            r[2*k+1] = pk;
        end
        return r;
    endfunction

    function automatic logic [15:0] ref0(input logic [5:0] m);
        logic [63:0] r;
        r = ref_code(6, 0, {26'd0, m});
        return r[15:0];
    endfunction

    function automatic logic [23:0] ref1(input logic [5:0] m);
        logic [63:0] r;
        r = ref_code(6, 1, {26'd0, m});
        return r[23:0];
    endfunction

    task automatic check_now(input string tag, input logic [15:0] e0,
                             input logic [23:0] e1);
        compared++;
        assert (out0 === e0) else begin
            mismatched++;
            $error("FAIL %s step0 observed=%h expected=%h", tag, out0, e0);
        end
        compared++;
        assert (out1 === e1) else begin
            mismatched++;
            $error("FAIL %s step1 observed=%h expected=%h", tag, out1, e1);
        end
    endtask

    // Drive at the falling edge and queue the expected codeword.
    task automatic drive(input logic [5:0] m, input logic [15:0] e0,
                         input logic [23:0] e1);
        @(negedge clk);
        msg_in = m;
        q0.push_back(e0);
        q1.push_back(e1);
    endtask

    task automatic collect(input string tag);
        logic [15:0] e0;
        logic [23:0] e1;
        @(posedge clk);
        #1;
        compared++;
        assert (q0.size() > 0 && q1.size() > 0) else begin
            mismatched++;
            $error("FAIL %s queue observed=empty expected=entry", tag);
        end
        if (q0.size() > 0 && q1.size() > 0) begin
            e0 = q0.pop_front();
            e1 = q1.pop_front();
            check_now(tag, e0, e1);
        end
    endtask

    initial begin
        logic [5:0] r;

        rst = 1'b1;
        msg_in = 6'h3F;
        #2;
        check_now("reset_hold", 16'h0000, 24'h000000);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check_now("release_no_edge", 16'h0000, 24'h000000);

        drive(6'b000000, 16'h0000, 24'h000000);
        collect("zero");
        drive(6'b000001, 16'h0029, 24'h002081);
        collect("bit0");
        drive(6'b100000, 16'hA400, ref1(6'b100000));
        collect("bit5");
        drive(6'b111111, 16'h855D, ref1(6'b111111));
        collect("all_ones");
        drive(6'b100001, 16'hA429, ref1(6'b100001));
        collect("linear");
        drive(6'b010101, ref0(6'b010101), ref1(6'b010101));
        collect("alt_a");
        drive(6'b101010, ref0(6'b101010), ref1(6'b101010));
        collect("alt_b");

        for (int i = 0; i < 24; i++) begin
            r = 6'($urandom);
            drive(r, ref0(r), ref1(r));
            collect("random");
        end

        // Asynchronous reset mid-operation, between clock edges.
        drive(6'b111111, 16'h855D, ref1(6'b111111));
        collect("pre_async");
        @(negedge clk);
        msg_in = 6'b000001;
        #1 rst = 1'b1;
        #1;
        check_now("async_reset", 16'h0000, 24'h000000);
        #1 rst = 1'b0;
        #1;
        check_now("async_release", 16'h0000, 24'h000000);
        q0.push_back(16'h0029);
        q1.push_back(24'h002081);
        collect("first_after_reset");

        compared++;
        assert (q0.size() == 0 && q1.size() == 0) else begin
            mismatched++;
            $error("FAIL drain observed=%0d expected=0", q0.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
